// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the instruction loader: the loader FSM state
// encoding, the load-stream byte width and the number of bytes per word.
// -----------------------------------------------------------------------------
package loader_pkg;

    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_BYTES = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } load_state_t;

    // True when the byte counter points at the final byte of a word
    function automatic logic is_last_byte(input logic [1:0] cnt);
        return (cnt == 2'(BYTES_PER_WORD - 1));
    endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// -----------------------------------------------------------------------------
// loader_word_assembler
// Packs incoming bytes big-endian into an instruction word. Only the first
// three bytes are stored; the fourth is combined on the fly so the complete
// word is available in the cycle the last byte is accepted.
// Ports:
//   CLK, RST          clock, synchronous active-low reset
//   i_shift_en        accept i_byte into the word this cycle
//   i_clear           restart at byte 0 (takes priority over i_shift_en)
//   i_byte            incoming byte
//   o_word_next       stored bytes followed by i_byte (the full word when
//                     o_word_complete is high)
//   o_word_complete   the byte being accepted is the last byte of the word
// -----------------------------------------------------------------------------
module loader_word_assembler
    import loader_pkg::*;
#(
    parameter int INST_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  i_shift_en,
    input  logic                  i_clear,
    input  logic [BYTE_W-1:0]     i_byte,
    output logic [INST_WIDTH-1:0] o_word_next,
    output logic                  o_word_complete
);

    localparam int SHIFT_W = INST_WIDTH - BYTE_W;

    logic [SHIFT_W-1:0] r_shift;
    logic [1:0]         r_byte_cnt;

    assign o_word_next     = {r_shift, i_byte};
    assign o_word_complete = i_shift_en && is_last_byte(r_byte_cnt);

    // Byte shift register and 2-bit byte position counter (wraps after byte 4)
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_shift    <= '0;
            r_byte_cnt <= 2'd0;
        end else if (i_clear) begin
            r_byte_cnt <= 2'd0;
        end else if (i_shift_en) begin
            r_shift    <= o_word_next[SHIFT_W-1:0];
            r_byte_cnt <= r_byte_cnt + 2'd1;
        end else begin
            r_byte_cnt <= r_byte_cnt;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// -----------------------------------------------------------------------------
// instruction_loader
// Receives a byte stream (one word-count header byte N, then N big-endian
// 4-byte words), writes each word to instruction memory at consecutive
// addresses from 0 and holds the CPU in reset until the image is complete.
// Ports:
//   CLK, RST                     clock, synchronous active-low reset
//   Start                        load request (IDLE, DONE, ERR only)
//   Byte_In/Byte_Valid/Byte_Ready byte stream handshake
//   Mem_Write_En/Addr/Data       single-cycle memory write port
//   CPU_Hold                     low only once the load completed
//   Load_Done / Load_Error       load result (illegal header -> error)
// -----------------------------------------------------------------------------
module instruction_loader
    import loader_pkg::*;
#(
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Start,
    input  logic [7:0]            Byte_In,
    input  logic                  Byte_Valid,
    output logic                  Byte_Ready,
    output logic                  Mem_Write_En,
    output logic [ADDR_WIDTH-1:0] Mem_Write_Addr,
    output logic [INST_WIDTH-1:0] Mem_Write_Data,
    output logic                  CPU_Hold,
    output logic                  Load_Done,
    output logic                  Load_Error
);

    // One extra index bit so that a full 2^ADDR_WIDTH-word image can be
    // compared against N without wrapping back to zero.
    localparam int IDX_W = ADDR_WIDTH + 1;
    localparam int CMP_W = (IDX_W > BYTE_W) ? IDX_W : BYTE_W;
    localparam logic [CMP_W-1:0] MAX_WORDS = {{(CMP_W-1){1'b0}}, 1'b1} << ADDR_WIDTH;

    load_state_t             r_state;
    load_state_t             w_state_next;
    logic [IDX_W-1:0]        r_word_idx;
    logic [IDX_W-1:0]        w_idx_inc;
    logic [BYTE_W-1:0]       r_num_words;
    logic                    w_accept;
    logic                    w_shift_en;
    logic                    w_clear;
    logic                    w_word_complete;
    logic                    w_hdr_illegal;
    logic                    w_last_word;
    logic [INST_WIDTH-1:0]   w_word_next;

    assign w_accept      = Byte_Valid && Byte_Ready;
    assign w_shift_en    = w_accept && (r_state == ST_BYTES);
    assign w_clear       = (r_state == ST_COUNT);
    assign w_idx_inc     = r_word_idx + {{(IDX_W-1){1'b0}}, 1'b1};
    assign w_hdr_illegal = (CMP_W'(Byte_In) == {CMP_W{1'b0}}) || (CMP_W'(Byte_In) > MAX_WORDS);
    assign w_last_word   = (CMP_W'(w_idx_inc) == CMP_W'(r_num_words));

    loader_word_assembler #(
        .INST_WIDTH (INST_WIDTH)
    ) u_assembler (
        .CLK             (CLK),
        .RST             (RST),
        .i_shift_en      (w_shift_en),
        .i_clear         (w_clear),
        .i_byte          (Byte_In),
        .o_word_next     (w_word_next),
        .o_word_complete (w_word_complete)
    );

    // Next-state logic of the load FSM
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (Start) w_state_next = ST_COUNT;
                else       w_state_next = ST_IDLE;
            end
            ST_COUNT: begin
                if (w_accept) w_state_next = w_hdr_illegal ? ST_ERR : ST_BYTES;
                else          w_state_next = ST_COUNT;
            end
            ST_BYTES: begin
                if (w_word_complete) w_state_next = ST_WRITE;
                else                 w_state_next = ST_BYTES;
            end
            ST_WRITE: begin
                if (w_last_word) w_state_next = ST_DONE;
                else             w_state_next = ST_BYTES;
            end
            ST_DONE: begin
                if (Start) w_state_next = ST_COUNT;
                else       w_state_next = ST_DONE;
            end
            ST_ERR: begin
                if (Start) w_state_next = ST_COUNT;
                else       w_state_next = ST_ERR;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs (outputs decoded from next state)
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state        <= ST_IDLE;
            r_word_idx     <= '0;
            r_num_words    <= '0;
            Byte_Ready     <= 1'b0;
            Mem_Write_En   <= 1'b0;
            Mem_Write_Addr <= '0;
            Mem_Write_Data <= '0;
            CPU_Hold       <= 1'b1;
            Load_Done      <= 1'b0;
            Load_Error     <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            Byte_Ready   <= (w_state_next == ST_COUNT) || (w_state_next == ST_BYTES);
            Mem_Write_En <= (w_state_next == ST_WRITE);
            CPU_Hold     <= (w_state_next != ST_DONE);
            Load_Done    <= (w_state_next == ST_DONE);
            Load_Error   <= (w_state_next == ST_ERR);

            if ((r_state == ST_COUNT) && w_accept) begin
                r_num_words <= Byte_In;
                r_word_idx  <= '0;
            end else if (r_state == ST_WRITE) begin
                r_word_idx  <= w_idx_inc;
            end else begin
                r_word_idx  <= r_word_idx;
            end

            // Address/data are only updated when a write is issued
            if (w_state_next == ST_WRITE) begin
                Mem_Write_Addr <= r_word_idx[ADDR_WIDTH-1:0];
                Mem_Write_Data <= w_word_next;
            end else begin
                Mem_Write_Addr <= Mem_Write_Addr;
                Mem_Write_Data <= Mem_Write_Data;
            end
        end
    end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 The block SHALL have parameter INST_WIDTH, default 32, meaning the instruction word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 6, meaning the instruction-memory word-address width (64 words).
REQ-003 The block SHALL have port CLK  input  1  system clock; all state changes on the rising edge.
REQ-004 The block SHALL have port RST  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port Start  input  1  load request, sampled in IDLE, DONE and ERR.
REQ-006 The block SHALL have port Byte_In  input  8  incoming load-stream byte.
REQ-007 The block SHALL have port Byte_Valid  input  1  Byte_In is valid this cycle.
REQ-008 The block SHALL have port Byte_Ready  output  1  the loader accepts Byte_In this cycle.
REQ-009 The block SHALL have port Mem_Write_En  output  1  single-cycle instruction-memory write strobe.
REQ-010 The block SHALL have port Mem_Write_Addr  output  ADDR_WIDTH  instruction-memory word address.
REQ-011 The block SHALL have port Mem_Write_Data  output  INST_WIDTH  instruction word to write.
REQ-012 The block SHALL have port CPU_Hold  output  1  holds the processor in reset while high.
REQ-013 The block SHALL have port Load_Done  output  1  image loaded successfully.
REQ-014 The block SHALL have port Load_Error  output  1  the header word count was illegal.

Function
REQ-015 The block SHALL implement states IDLE, COUNT, BYTES, WRITE, DONE and ERR.
REQ-016 A byte SHALL be accepted only in a cycle with Byte_Valid=1 and Byte_Ready=1.
REQ-017 Byte_Ready SHALL be 1 in COUNT and BYTES only, and 0 in every other state.
REQ-018 IDLE SHALL go to COUNT when Start=1; the block SHALL otherwise stay in IDLE.
REQ-019 In COUNT, the first accepted byte SHALL be latched as word count N.
REQ-020 N=0 or N>2^ADDR_WIDTH SHALL cause a transition to ERR; otherwise the block SHALL go to BYTES with word index 0.
REQ-021 In BYTES, the block SHALL accept 4 bytes big-endian: the first byte goes to bits 31:24 and the fourth to bits 7:0.
REQ-022 After the fourth byte is accepted, the block SHALL go to WRITE.
REQ-023 WRITE SHALL last exactly 1 cycle with Mem_Write_En=1, Mem_Write_Addr=word index and Mem_Write_Data=assembled word.
REQ-024 After WRITE, the word index SHALL increment; the block SHALL go to DONE if the index equals N, otherwise to BYTES.
REQ-025 Mem_Write_Addr and Mem_Write_Data SHALL hold their last values outside WRITE, and Mem_Write_En SHALL be 0 outside WRITE.
REQ-026 CPU_Hold SHALL be 1 in all states except DONE.
REQ-027 In DONE, Load_Done SHALL be 1; Load_Error SHALL be 1 in ERR only.
REQ-028 Start=1 in DONE or ERR SHALL clear Load_Done and Load_Error and go to COUNT next cycle.
REQ-029 Start SHALL be ignored in COUNT, BYTES and WRITE.
REQ-030 Byte_Valid without Byte_Ready SHALL have no effect, and bytes SHALL never be dropped or duplicated.
REQ-031 Gaps in Byte_Valid SHALL stall assembly indefinitely with no timeout.
REQ-032 Maximum throughput SHALL be 1 word per 5 cycles (4 accept cycles plus 1 WRITE cycle).
REQ-033 With N=2^ADDR_WIDTH, the final write SHALL be at address 2^ADDR_WIDTH-1, and the index counter SHALL be ADDR_WIDTH+1 bits so the DONE compare does not wrap.

Reset
REQ-034 With RST=0 at a clock edge, the block SHALL enter IDLE and set Byte_Ready=0, Mem_Write_En=0, Mem_Write_Addr=0, Mem_Write_Data=0, CPU_Hold=1, Load_Done=0, Load_Error=0, word index=0, N=0 and the byte counter to 0.
REQ-035 Reset mid-load SHALL discard any partial word without issuing a memory write, and CPU_Hold SHALL remain 1 throughout.

Structure
REQ-036 The state encoding, BYTES_PER_WORD=4 and the byte width 8 SHALL reside in a shared package loader_pkg.
REQ-037 A single sub-module loader_word_assembler SHALL contain the byte shift register and the 2-bit byte counter, with shift-enable and clear inputs and a word-complete output.
REQ-038 The FSM, word index, N register and output registers SHALL reside in instruction_loader.

Verification
REQ-039 Scenario: Start, then bytes 0x02, 0x20,0x08,0x00,0x05, 0x00,0x00,0x00,0x0C with continuous valid -> writes 0x20080005@0 and 0x0000000C@1, each Mem_Write_En lasting 1 cycle; Load_Done=1 and CPU_Hold=0 in the cycle after the second write.
REQ-040 Scenario: header byte 0x00 -> ERR with Load_Error=1, CPU_Hold=1, no write; header 0x41 with ADDR_WIDTH=6 -> same response.
REQ-041 Scenario: N=0x40 with random Byte_Valid gaps -> exactly 64 writes at addresses 0..63 with data matching the stream, then DONE.
REQ-042 Scenario: RST=0 after 2 bytes of word 1 -> no write, IDLE state and all reset values next cycle; a subsequent Start reloads correctly from address 0.
REQ-043 Scenario: Byte_Valid held high during WRITE -> that byte is not consumed and is taken as the first byte of the next word.
REQ-044 Scenario: Start pulsed during BYTES -> no effect; Start in DONE -> Load_Done=0 and CPU_Hold=1 in the next cycle.
